// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: decode-time forward selects registered into EX,
// branch flush, variable-latency memory stall. Optional load-use bubble: HAZARD_LOAD_USE_STALL_EN.
module hazard_fwd_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              DMemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MemTimeoutErr
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [TO_W-1:0]   r_cnt, w_cnt_nxt;
  logic              w_err_nxt;

  logic [REG_AW-1:0] r_rd_e, r_rd_m;
  logic              r_regwrite_e, r_load_e, r_regwrite_m;

  logic              w_memstall, w_load_use, w_flush_d, w_flush_e;
  logic [1:0]        w_fwd_a, w_fwd_b;

  // Stalls and flushes drop the moment reset asserts, even mid-wait
  assign w_memstall = MemReqM & ~DMemReadyM & ~reset;

`ifdef HAZARD_LOAD_USE_STALL_EN
  assign w_load_use = r_load_e && (r_rd_e != '0) && ((r_rd_e == Rs1D) || (r_rd_e == Rs2D))
                      && !PCSrcE && !w_memstall && !reset;
`else
  logic w_unused_load;
  assign w_unused_load = r_load_e;
  assign w_load_use    = 1'b0;
`endif

  assign w_flush_d = PCSrcE & ~w_memstall & ~reset;
  assign w_flush_e = (PCSrcE | w_load_use) & ~w_memstall & ~reset;

  assign StallF = w_memstall | w_load_use;
  assign StallD = w_memstall | w_load_use;
  assign StallE = w_memstall;
  assign StallM = w_memstall;
  assign FlushD = w_flush_d;
  assign FlushE = w_flush_e;

  // EX-stage producer wins over MEM-stage producer; x0 never forwards
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (Rs1D != '0 && r_regwrite_e && r_rd_e == Rs1D)      w_fwd_a = 2'b10;
    else if (Rs1D != '0 && r_regwrite_m && r_rd_m == Rs1D) w_fwd_a = 2'b01;
    if (Rs2D != '0 && r_regwrite_e && r_rd_e == Rs2D)      w_fwd_b = 2'b10;
    else if (Rs2D != '0 && r_regwrite_m && r_rd_m == Rs2D) w_fwd_b = 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory wait FSM with saturating wait counter and sticky timeout flag
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = MemTimeoutErr;
    case (r_state)
      ST_RUN: begin
        if (w_memstall) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = TO_W'(1);
        end
      end
      ST_WAIT: begin
        if (r_cnt == TO_W'(MEM_TIMEOUT)) w_err_nxt = 1'b1;
        if (DMemReadyM) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + TO_W'(1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      MemTimeoutErr <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      MemTimeoutErr <= w_err_nxt;
    end
  end

  // ID/EX shadow and registered forward selects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_e       <= '0;
      r_regwrite_e <= 1'b0;
      r_load_e     <= 1'b0;
      ForwardAE    <= 2'b00;
      ForwardBE    <= 2'b00;
    end else if (w_flush_e) begin
      r_rd_e       <= '0;
      r_regwrite_e <= 1'b0;
      r_load_e     <= 1'b0;
      ForwardAE    <= 2'b00;
      ForwardBE    <= 2'b00;
    end else if (!w_memstall) begin
      r_rd_e       <= RdD;
      r_regwrite_e <= RegWriteD;
      r_load_e     <= MemToRegD;
      ForwardAE    <= w_fwd_a;
      ForwardBE    <= w_fwd_b;
    end
  end

  // EX/MEM shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_m       <= '0;
      r_regwrite_m <= 1'b0;
    end else if (!w_memstall) begin
      r_rd_m       <= r_rd_e;
      r_regwrite_m <= r_regwrite_e;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl (MEM_TIMEOUT=4); follows HAZARD_LOAD_USE_STALL_EN if defined.
module tb_hazard_fwd_ctrl;

  logic       clk, reset;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD, MemToRegD, PCSrcE, MemReqM, DMemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeoutErr;
  int         n_vec = 0;
  int         n_err = 0;

  hazard_fwd_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .DMemReadyM(DMemReadyM), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .MemTimeoutErr(MemTimeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; MemToRegD = ld;
  endtask

  task automatic idle(input int n);
    set_d(0, 0, 0, 0, 0);
    PCSrcE = 0; MemReqM = 0; DMemReadyM = 1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1;
    idle(0);
    #2;
    n_vec++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      n_err++; $display("FAIL reset_fwd: got %b want 0000", {ForwardAE, ForwardBE});
    end
    n_vec++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeoutErr} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0000000",
                        {StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeoutErr});
    end
    @(negedge clk);
    reset = 0;
    idle(2);
  endtask

  task automatic test_fwd_ex();
    set_d(0, 0, 5, 1, 0); tick();
    set_d(5, 0, 0, 0, 0); #1;
    n_vec++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b0) begin
      n_err++; $display("FAIL fwd_ex_nostall: got %b want 000000",
                        {StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    tick();
    n_vec++;
    if ({ForwardAE, ForwardBE} !== 4'b1000) begin
      n_err++; $display("FAIL fwd_ex: got %b want 1000", {ForwardAE, ForwardBE});
    end
    set_d(0, 5, 0, 0, 0); tick();
    n_vec++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      n_err++; $display("FAIL fwd_mem_b: got %b want 0001", {ForwardAE, ForwardBE});
    end
    idle(2);
  endtask

  task automatic test_fwd_priority();
    set_d(0, 0, 5, 1, 0); tick();
    set_d(0, 0, 5, 1, 0); tick();
    set_d(0, 5, 0, 0, 0); tick();
    n_vec++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) begin
      n_err++; $display("FAIL fwd_ex_wins: got %b want 0010", {ForwardAE, ForwardBE});
    end
    idle(2);
    set_d(0, 0, 5, 1, 0); tick();
    set_d(0, 0, 0, 1, 0); tick();
    set_d(0, 5, 0, 0, 0); tick();
    n_vec++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      n_err++; $display("FAIL fwd_x0: got %b want 0001", {ForwardAE, ForwardBE});
    end
    idle(2);
  endtask

  task automatic test_load_use();
    set_d(0, 0, 7, 1, 1); tick();
    set_d(7, 0, 0, 0, 0); #1;
`ifdef HAZARD_LOAD_USE_STALL_EN
    n_vec++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b110001) begin
      n_err++; $display("FAIL lu_stall: got %b want 110001",
                        {StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    tick();
    n_vec++;
    if ({StallF, StallD, FlushE, ForwardAE} !== 5'b00000) begin
      n_err++; $display("FAIL lu_bubble: got %b want 00000", {StallF, StallD, FlushE, ForwardAE});
    end
    tick();
    n_vec++;
    if (ForwardAE !== 2'b01) begin
      n_err++; $display("FAIL lu_fwd: got %b want 01", ForwardAE);
    end
`else
    n_vec++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b0) begin
      n_err++; $display("FAIL lu_nostall: got %b want 000000",
                        {StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    tick();
    n_vec++;
    if (ForwardAE !== 2'b10) begin
      n_err++; $display("FAIL lu_fwd: got %b want 10", ForwardAE);
    end
`endif
    idle(2);
  endtask

  task automatic test_memstall();
    set_d(0, 0, 5, 1, 0); tick();
    set_d(5, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0);
    MemReqM = 1; DMemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b111100) begin
        n_err++; $display("FAIL mem_stall[%0d]: got %b want 111100", i,
                          {StallF, StallD, StallE, StallM, FlushD, FlushE});
      end
      tick();
      n_vec++;
      if (ForwardAE !== 2'b10) begin
        n_err++; $display("FAIL mem_freeze[%0d]: got %b want 10", i, ForwardAE);
      end
    end
    DMemReadyM = 1; #1;
    n_vec++;
    if ({StallF, StallD, StallE, StallM} !== 4'b0000) begin
      n_err++; $display("FAIL mem_release: got %b want 0000", {StallF, StallD, StallE, StallM});
    end
    tick();
    n_vec++;
    if (ForwardAE !== 2'b00 || MemTimeoutErr !== 1'b0) begin
      n_err++; $display("FAIL mem_resume: got fwd=%b err=%b want fwd=00 err=0", ForwardAE, MemTimeoutErr);
    end
    idle(2);
  endtask

  task automatic test_branch();
    PCSrcE = 1; MemReqM = 1; DMemReadyM = 0; #1;
    n_vec++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b111100) begin
      n_err++; $display("FAIL br_stalled: got %b want 111100",
                        {StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    tick();
    DMemReadyM = 1; #1;
    n_vec++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b000011) begin
      n_err++; $display("FAIL br_flush: got %b want 000011",
                        {StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    idle(2);
    set_d(0, 0, 7, 1, 1); tick();
    set_d(7, 0, 0, 0, 0); PCSrcE = 1; #1;
    n_vec++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b000011) begin
      n_err++; $display("FAIL br_lu: got %b want 000011",
                        {StallF, StallD, StallE, StallM, FlushD, FlushE});
    end
    idle(2);
  endtask

  task automatic test_timeout();
    set_d(0, 0, 3, 1, 0); tick();
    set_d(3, 3, 0, 0, 0); tick();
    MemReqM = 1; DMemReadyM = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (MemTimeoutErr !== 1'b0) begin
        n_err++; $display("FAIL to_early[%0d]: got %b want 0", i, MemTimeoutErr);
      end
    end
    tick();
    n_vec++;
    if (MemTimeoutErr !== 1'b1) begin
      n_err++; $display("FAIL to_set: got %b want 1", MemTimeoutErr);
    end
    tick();
    n_vec++;
    if ({MemTimeoutErr, StallM, ForwardAE, ForwardBE} !== 6'b111010) begin
      n_err++; $display("FAIL to_sticky: got %b want 111010",
                        {MemTimeoutErr, StallM, ForwardAE, ForwardBE});
    end
    #2 reset = 1; #1;
    n_vec++;
    if ({MemTimeoutErr, StallF, StallD, StallE, StallM, ForwardAE, ForwardBE} !== 9'b0) begin
      n_err++; $display("FAIL to_reset: got %b want 000000000",
                        {MemTimeoutErr, StallF, StallD, StallE, StallM, ForwardAE, ForwardBE});
    end
    idle(0);
    @(negedge clk);
    reset = 0;
    tick();
    n_vec++;
    if (MemTimeoutErr !== 1'b0) begin
      n_err++; $display("FAIL to_after_reset: got %b want 0", MemTimeoutErr);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_priority();
    test_load_use();
    test_memstall();
    test_branch();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
